// File: rtl/sdrc_req_split.sv
// sdrc_req_split: splits one application request into page-bounded, burst-capped chunks
// for the bank stage. Optional macro SDRC_WRAP_EN: wrap requests issue a single unsplit chunk.
module sdrc_req_split #(
    parameter int SDR_REQ_ID_W = 4,
    parameter int REQ_BW       = 12,
    parameter int COL_BITS     = 9,
    parameter int BANK_BITS    = 2,
    parameter int ROW_BITS     = 13,
    parameter int APP_AW       = ROW_BITS + BANK_BITS + COL_BITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    app_req,
    input  logic [APP_AW-1:0]       app_req_addr,
    input  logic [REQ_BW-1:0]       app_req_len,
    input  logic                    app_req_wr,
    input  logic [SDR_REQ_ID_W-1:0] app_req_id,
    input  logic                    app_req_wrap,
    output logic                    app_req_ack,
    input  logic [REQ_BW-1:0]       cfg_max_burst,
    output logic                    r2b_req,
    output logic [SDR_REQ_ID_W-1:0] r2b_req_id,
    output logic                    r2b_start,
    output logic                    r2b_last,
    output logic                    r2b_wrap,
    output logic                    r2b_write,
    output logic [BANK_BITS-1:0]    r2b_ba,
    output logic [12:0]             r2b_raddr,
    output logic [12:0]             r2b_caddr,
    output logic [REQ_BW-1:0]       r2b_len,
    input  logic                    b2r_ack,
    output logic                    busy
);

    localparam int CW     = (REQ_BW > COL_BITS + 1) ? REQ_BW : COL_BITS + 1;
    localparam int ADDR_W = 13;
    localparam logic [CW-1:0] PAGE_WORDS = CW'(2 ** COL_BITS);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [APP_AW-1:0]       addr_q, addr_d;
    logic [REQ_BW-1:0]       rem_q, rem_d;
    logic                    first_q, first_d;
    logic                    wr_q, wr_d;
    logic [SDR_REQ_ID_W-1:0] id_q, id_d;
    logic                    ack_q, ack_d;
`ifdef SDRC_WRAP_EN
    logic                    wrap_q, wrap_d;
`else
    logic                    unused_wrap;
    assign unused_wrap = app_req_wrap;
`endif

    logic [COL_BITS-1:0] col;
    logic [CW-1:0]       page_rem;
    logic [CW-1:0]       rem_w;
    logic [CW-1:0]       cap_w;
    logic [CW-1:0]       chunk_w;
    logic [REQ_BW-1:0]   chunk;
    logic                last_chunk;

    // Chunk size depends only on registered state so r2b_* hold steady under backpressure.
    always_comb begin
        col      = addr_q[COL_BITS-1:0];
        page_rem = PAGE_WORDS - CW'(col);
        rem_w    = CW'(rem_q);
        cap_w    = CW'(cfg_max_burst);
        chunk_w  = rem_w;
        if (page_rem < chunk_w) begin
            chunk_w = page_rem;
        end
        if ((cap_w != '0) && (cap_w < chunk_w)) begin
            chunk_w = cap_w;
        end
`ifdef SDRC_WRAP_EN
        if (wrap_q) begin
            chunk_w = (rem_w > PAGE_WORDS) ? PAGE_WORDS : rem_w;
        end
`endif
        chunk = chunk_w[REQ_BW-1:0];
    end

`ifdef SDRC_WRAP_EN
    assign last_chunk = wrap_q || (chunk == rem_q);
`else
    assign last_chunk = (chunk == rem_q);
`endif

    // NOTE: every signal assigned here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        first_d = first_q;
        wr_d    = wr_q;
        id_d    = id_q;
        ack_d   = 1'b0;
`ifdef SDRC_WRAP_EN
        wrap_d  = wrap_q;
`endif
        case (state_q)
            IDLE: begin
                // The ack cycle itself must not re-accept a request still held high.
                if (app_req && !ack_q) begin
                    addr_d  = app_req_addr;
                    rem_d   = app_req_len;
                    first_d = 1'b1;
                    wr_d    = app_req_wr;
                    id_d    = app_req_id;
                    ack_d   = 1'b1;
`ifdef SDRC_WRAP_EN
                    wrap_d  = app_req_wrap;
`endif
                    if (app_req_len != '0) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (b2r_ack) begin
                    rem_d   = rem_q - chunk;
                    // A chunk never crosses a page, so a plain add carries into bank, then row.
                    addr_d  = addr_q + APP_AW'(chunk);
                    first_d = 1'b0;
                    if (last_chunk) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
            wr_q    <= 1'b0;
            id_q    <= '0;
            ack_q   <= 1'b0;
`ifdef SDRC_WRAP_EN
            wrap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            wr_q    <= wr_d;
            id_q    <= id_d;
            ack_q   <= ack_d;
`ifdef SDRC_WRAP_EN
            wrap_q  <= wrap_d;
`endif
        end
    end

    assign app_req_ack = ack_q;
    assign busy        = (state_q != IDLE);
    assign r2b_req     = (state_q == ISSUE);

    always_comb begin
        r2b_req_id = '0;
        r2b_start  = 1'b0;
        r2b_last   = 1'b0;
        r2b_wrap   = 1'b0;
        r2b_write  = 1'b0;
        r2b_ba     = '0;
        r2b_raddr  = '0;
        r2b_caddr  = '0;
        r2b_len    = '0;
        if (state_q == ISSUE) begin
            r2b_req_id = id_q;
            r2b_start  = first_q;
            r2b_last   = last_chunk;
            r2b_write  = wr_q;
            r2b_ba     = addr_q[COL_BITS +: BANK_BITS];
            r2b_raddr  = ADDR_W'(addr_q[APP_AW-1 -: ROW_BITS]);
            r2b_caddr  = ADDR_W'(col);
            r2b_len    = chunk;
`ifdef SDRC_WRAP_EN
            r2b_wrap   = wrap_q;
`endif
        end
    end

endmodule

// File: tb/tb_sdrc_req_split.sv
// Testbench for sdrc_req_split: directed and random requests checked against a queue-based
// chunk model; honours SDRC_WRAP_EN when defined.
module tb_sdrc_req_split;

    localparam int ID_W      = 4;
    localparam int REQ_BW    = 12;
    localparam int COL_BITS  = 9;
    localparam int BANK_BITS = 2;
    localparam int ROW_BITS  = 13;
    localparam int APP_AW    = ROW_BITS + BANK_BITS + COL_BITS;
    localparam int PAGE      = 1 << COL_BITS;
    localparam int NBANK     = 1 << BANK_BITS;
`ifdef SDRC_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef struct {
        int ba;
        int row;
        int col;
        int len;
        bit start;
        bit last;
        bit wrap;
    } chunk_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              app_req;
    logic [APP_AW-1:0] app_req_addr;
    logic [REQ_BW-1:0] app_req_len;
    logic              app_req_wr;
    logic [ID_W-1:0]   app_req_id;
    logic              app_req_wrap;
    logic              app_req_ack;
    logic [REQ_BW-1:0] cfg_max_burst;
    logic              r2b_req;
    logic [ID_W-1:0]   r2b_req_id;
    logic              r2b_start;
    logic              r2b_last;
    logic              r2b_wrap;
    logic              r2b_write;
    logic [BANK_BITS-1:0] r2b_ba;
    logic [12:0]       r2b_raddr;
    logic [12:0]       r2b_caddr;
    logic [REQ_BW-1:0] r2b_len;
    logic              b2r_ack;
    logic              busy;

    chunk_t exp_q[$];
    int     total = 0;
    int     bad   = 0;

    sdrc_req_split dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .app_req       (app_req),
        .app_req_addr  (app_req_addr),
        .app_req_len   (app_req_len),
        .app_req_wr    (app_req_wr),
        .app_req_id    (app_req_id),
        .app_req_wrap  (app_req_wrap),
        .app_req_ack   (app_req_ack),
        .cfg_max_burst (cfg_max_burst),
        .r2b_req       (r2b_req),
        .r2b_req_id    (r2b_req_id),
        .r2b_start     (r2b_start),
        .r2b_last      (r2b_last),
        .r2b_wrap      (r2b_wrap),
        .r2b_write     (r2b_write),
        .r2b_ba        (r2b_ba),
        .r2b_raddr     (r2b_raddr),
        .r2b_caddr     (r2b_caddr),
        .r2b_len       (r2b_len),
        .b2r_ack       (b2r_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({app_req_ack, r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap,
                    r2b_write, r2b_ba, r2b_raddr, r2b_caddr, r2b_len, busy});
    endfunction

    function automatic int mk_addr(input int row, input int bank, input int col);
        return (row << (COL_BITS + BANK_BITS)) | (bank << COL_BITS) | col;
    endfunction

    // Reference: walk the request word range, cutting at page ends and at the burst cap.
    task automatic model(input int addr, input int len, input int cap, input bit wrap);
        int     a;
        int     r;
        int     c;
        int     room;
        bit     first;
        chunk_t ch;
        exp_q.delete();
        a     = addr;
        r     = len;
        first = 1'b1;
        if (WRAP_EN && wrap && (len > 0)) begin
            ch.col   = a % PAGE;
            ch.ba    = (a / PAGE) % NBANK;
            ch.row   = a / (PAGE * NBANK);
            ch.len   = (len > PAGE) ? PAGE : len;
            ch.start = 1'b1;
            ch.last  = 1'b1;
            ch.wrap  = 1'b1;
            exp_q.push_back(ch);
            return;
        end
        while (r > 0) begin
            room = PAGE - (a % PAGE);
            c    = r;
            if (room < c) c = room;
            if ((cap != 0) && (cap < c)) c = cap;
            ch.col   = a % PAGE;
            ch.ba    = (a / PAGE) % NBANK;
            ch.row   = a / (PAGE * NBANK);
            ch.len   = c;
            ch.start = first;
            ch.last  = (c == r);
            ch.wrap  = 1'b0;
            exp_q.push_back(ch);
            r     = r - c;
            a     = (a + c) % (1 << APP_AW);
            first = 1'b0;
        end
    endtask

    task automatic run_req(input int row, input int bank, input int col, input int len,
                           input int cap, input bit wr, input bit wrap, input int stall);
        int     addr;
        int     n;
        int     idx;
        int     cyc;
        int     wait_cnt;
        bit     ack_now;
        int     id;
        chunk_t e;
        addr = mk_addr(row, bank, col);
        model(addr, len, cap, wrap);
        n  = exp_q.size();
        id = int'($urandom_range(0, (1 << ID_W) - 1));
        cfg_max_burst = REQ_BW'(cap);
        app_req_addr  = APP_AW'(addr);
        app_req_len   = REQ_BW'(len);
        app_req_wr    = wr;
        app_req_id    = ID_W'(id);
        app_req_wrap  = wrap;
        app_req       = 1'b1;
        @(posedge clk); #1;
        check("app_req_ack", 64'(app_req_ack), 64'(1));
        check("busy_after_accept", 64'(busy), 64'(n != 0));
        app_req  = 1'b0;
        idx      = 0;
        cyc      = 0;
        wait_cnt = 0;
        while (idx < n) begin
            e = exp_q[idx];
            check($sformatf("c%0d_req", idx),   64'(r2b_req),    64'(1));
            check($sformatf("c%0d_ba", idx),    64'(r2b_ba),     64'(e.ba));
            check($sformatf("c%0d_raddr", idx), 64'(r2b_raddr),  64'(e.row));
            check($sformatf("c%0d_caddr", idx), 64'(r2b_caddr),  64'(e.col));
            check($sformatf("c%0d_len", idx),   64'(r2b_len),    64'(e.len));
            check($sformatf("c%0d_start", idx), 64'(r2b_start),  64'(e.start));
            check($sformatf("c%0d_last", idx),  64'(r2b_last),   64'(e.last));
            check($sformatf("c%0d_wrap", idx),  64'(r2b_wrap),   64'(e.wrap));
            check($sformatf("c%0d_write", idx), 64'(r2b_write),  64'(wr));
            check($sformatf("c%0d_id", idx),    64'(r2b_req_id), 64'(id));
            if (cyc < stall) ack_now = 1'b0;
            else ack_now = ($urandom_range(0, 3) != 0) || (wait_cnt >= 4);
            b2r_ack = ack_now;
            @(posedge clk); #1;
            if (cyc == 0) check("ack_single_cycle", 64'(app_req_ack), 64'(0));
            if (ack_now) begin
                idx++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
            cyc++;
        end
        // A stray ack while idle must be ignored.
        b2r_ack = 1'b1;
        check("done_r2b_req", 64'(r2b_req), 64'(0));
        check("done_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        check("idle_r2b_req", 64'(r2b_req), 64'(0));
        check("idle_ack_low", 64'(app_req_ack), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        b2r_ack = 1'b0;
    endtask

    initial begin
        int cap;
        int len;
        int col;
        bit wrap;

        reset_n       = 1'b1;
        app_req       = 1'b0;
        app_req_addr  = '0;
        app_req_len   = '0;
        app_req_wr    = 1'b0;
        app_req_id    = '0;
        app_req_wrap  = 1'b0;
        cfg_max_burst = '0;
        b2r_ack       = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check("reset_outputs", outs_vec(), 64'(0));
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", outs_vec(), 64'(0));

        // Single chunk, page crossing into next bank, burst cap, backpressure.
        run_req(5, 1, 0,     16, 0, 1'b1, 1'b0, 0);
        run_req(5, 1, 'h1F8, 16, 0, 1'b0, 1'b0, 0);
        run_req(7, 0, 0,     10, 4, 1'b1, 1'b0, 0);
        run_req(7, 2, 0,     10, 4, 1'b0, 1'b0, 20);
        // Top address wraps back to row 0, bank 0.
        run_req(8191, 3, 'h1F0, 40, 0, 1'b1, 1'b0, 0);
        // Zero length: ack only.
        run_req(9, 1, 3, 0, 0, 1'b0, 1'b0, 0);
        // Wrap requests: single unsplit chunk when the feature is built in, split otherwise.
        run_req(5, 1, 'h1F8, 16, 0, 1'b0, 1'b1, 0);
        run_req(2, 3, 'h100, 600, 8, 1'b1, 1'b1, 0);

        // Reset during chunk 2 of a 3-chunk request.
        cfg_max_burst = REQ_BW'(4);
        app_req_addr  = APP_AW'(mk_addr(3, 2, 0));
        app_req_len   = REQ_BW'(10);
        app_req_wrap  = 1'b0;
        app_req       = 1'b1;
        @(posedge clk); #1;
        app_req = 1'b0;
        check("rst_c1_caddr", 64'(r2b_caddr), 64'(0));
        b2r_ack = 1'b1;
        @(posedge clk); #1;
        b2r_ack = 1'b0;
        check("rst_c2_caddr", 64'(r2b_caddr), 64'(4));
        check("rst_c2_start", 64'(r2b_start), 64'(0));
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", outs_vec(), 64'(0));
        @(posedge clk); #1;
        check("rst_hold_outputs", outs_vec(), 64'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release_idle", outs_vec(), 64'(0));
        run_req(4, 0, 0, 16, 0, 1'b1, 1'b0, 0);

        // Random requests.
        for (int i = 0; i < 40; i++) begin
            cap  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 64));
            len  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 300));
            col  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(PAGE - 24, PAGE - 1))
                                               : int'($urandom_range(0, PAGE - 1));
            wrap = ($urandom_range(0, 3) == 0);
            if (wrap && ($urandom_range(0, 1) == 0)) len = int'($urandom_range(PAGE - 8, 600));
            run_req(int'($urandom_range(0, (1 << ROW_BITS) - 1)), int'($urandom_range(0, NBANK - 1)),
                    col, len, cap, 1'($urandom_range(0, 1)), wrap, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
